// File: rtl/npu_hex_monitor.sv
// npu_hex_monitor -- NockPU front-panel monitor.
//
// Debounces the two push keys and turns key releases into a manual step
// pulse (key 0), a page advance (key 1) or, when both keys were held
// together, a channel advance. Snapshots the selected monitored word on its
// capture strobe and renders a NUM_DIGITS-nibble page of it onto active-low
// 7-segment displays.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   key_n       raw push keys, active low, asynchronous
//   ch_data     NUM_CHANNELS monitored words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_valid    per-channel capture strobe
//   step_pulse  one-cycle manual step
//   chan_sel    selected channel
//   page        displayed page
//   hex_out     digit d at [d*8 +: 8], bit7 = DP, all active low
//
// Build option: define NPU_HEX_BLANK_EN to blank leading-zero digits.
module npu_hex_monitor #(
    parameter int NUM_DIGITS      = 6,
    parameter int DATA_WIDTH      = 64,
    parameter int NUM_CHANNELS    = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         key_n,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CHANNELS-1:0]            ch_valid,
    output logic                               step_pulse,
    output logic [3:0]                         chan_sel,
    output logic [3:0]                         page,
    output logic [NUM_DIGITS*8-1:0]            hex_out
);

    localparam int NIB   = DATA_WIDTH / 4;
    localparam int PAGES = (NIB + NUM_DIGITS - 1) / NUM_DIGITS;
    localparam int CW    = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]                  key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [1:0]                  key_db_q, key_db_d;
    logic [1:0][CW-1:0]          cnt_q, cnt_d;
    logic                        chord_q, chord_d;
    logic                        step_pulse_q, step_pulse_d;
    logic [3:0]                  chan_sel_q, chan_sel_d;
    logic [3:0]                  page_q, page_d;
    logic [DATA_WIDTH-1:0]       snap_q, snap_d;
    logic                        stale_q, stale_d;
    logic [NUM_DIGITS*8-1:0]     hex_q, hex_d;

    logic [1:0]                  rel;
    logic                        chan_adv, page_adv, cap, sel_valid;
    logic [DATA_WIDTH-1:0]       sel_word;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // Key conditioning and event decode
    always_comb begin
        key_s1_d = key_n;
        key_s2_d = key_s1_q;
        key_db_d = key_db_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (key_s2_q[k] == key_db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                key_db_d[k] = ~key_db_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end

        // Events fire on the same edge the debounced value returns high.
        rel = ~key_db_q & key_db_d;

        chord_d = chord_q;
        if (key_db_q == 2'b00)      chord_d = 1'b1;
        else if (key_db_q == 2'b11) chord_d = 1'b0;

        // Inside a chord only the final release counts; the first is swallowed.
        chan_adv     = chord_q & (|rel) & (key_db_d == 2'b11);
        step_pulse_d = rel[0] & ~chord_q;
        page_adv     = rel[1] & ~chord_q;

        chan_sel_d = chan_sel_q;
        if (chan_adv)
            chan_sel_d = (chan_sel_q == 4'(NUM_CHANNELS - 1)) ? 4'd0 : chan_sel_q + 4'd1;

        page_d = page_q;
        if (chan_adv)
            page_d = 4'd0;
        else if (page_adv)
            page_d = (page_q == 4'(PAGES - 1)) ? 4'd0 : page_q + 4'd1;
    end

    // Capture of the selected channel; a channel switch in the same cycle wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_word  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (chan_sel_q == 4'(i)) begin
                sel_valid = ch_valid[i];
                sel_word  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        cap     = sel_valid & ~chan_adv;
        snap_d  = cap ? sel_word : snap_q;
        stale_d = chan_adv ? 1'b1 : (cap ? 1'b0 : stale_q);
    end

    // Display rendering from registered state
    always_comb begin
        int         n;
        logic [3:0] nib;
        logic       dp;
`ifdef NPU_HEX_BLANK_EN
        int         hi;
        hi = 0;
        for (int i = 0; i < NIB; i++)
            if (snap_q[i*4 +: 4] != 4'h0) hi = i;
`endif
        hex_d = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            n   = int'(page_q) * NUM_DIGITS + d;
            nib = 4'(snap_q >> (4 * n));
            dp  = (d == 0) ? ~stale_q : 1'b1;
            if (n < NIB) begin
                hex_d[d*8 +: 8] = {dp, seg7(nib)};
`ifdef NPU_HEX_BLANK_EN
                if (n != 0 && n > hi)
                    hex_d[d*8 +: 8] = {dp, 7'h7F};
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1_q     <= 2'b11;
            key_s2_q     <= 2'b11;
            key_db_q     <= 2'b11;
            cnt_q        <= '0;
            chord_q      <= 1'b0;
            step_pulse_q <= 1'b0;
            chan_sel_q   <= 4'd0;
            page_q       <= 4'd0;
            snap_q       <= '0;
            stale_q      <= 1'b1;
            hex_q        <= '1;
        end else begin
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            key_db_q     <= key_db_d;
            cnt_q        <= cnt_d;
            chord_q      <= chord_d;
            step_pulse_q <= step_pulse_d;
            chan_sel_q   <= chan_sel_d;
            page_q       <= page_d;
            snap_q       <= snap_d;
            stale_q      <= stale_d;
            hex_q        <= hex_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign chan_sel   = chan_sel_q;
    assign page       = page_q;
    assign hex_out    = hex_q;

endmodule
